// File: rtl/user_interrupt_controller_pkg.sv
// rtl/user_interrupt_controller_pkg.sv - shared constants and CSR decode for the user interrupt controller
package user_interrupt_controller_pkg;

  localparam int USER_IRQ_COUNT = 16;

  localparam logic [11:0] UIRQ_ENABLE_ADDR  = 12'hBC0;
  localparam logic [11:0] UIRQ_PENDING_ADDR = 12'hBC1;
  localparam logic [11:0] UIRQ_EDGE_ADDR    = 12'hBC2;
  localparam logic [11:0] UIRQ_RAW_ADDR     = 12'hBC3;

  typedef enum logic [2:0] {
    CSR_NONE,
    CSR_ENABLE,
    CSR_PENDING,
    CSR_EDGE,
    CSR_RAW
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    case (addr)
      UIRQ_ENABLE_ADDR:  return CSR_ENABLE;
      UIRQ_PENDING_ADDR: return CSR_PENDING;
      UIRQ_EDGE_ADDR:    return CSR_EDGE;
      UIRQ_RAW_ADDR:     return CSR_RAW;
      default:           return CSR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/user_interrupt_controller_if.sv
// rtl/user_interrupt_controller_if.sv - CSR access bus between the core and the user interrupt controller
interface user_interrupt_controller_if;

  logic        csrWriteEnable;
  logic        csrReadEnable;
  logic [11:0] csrWriteAddress;
  logic [11:0] csrReadAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        requestOutput;

  modport master (
    output csrWriteEnable,
    output csrReadEnable,
    output csrWriteAddress,
    output csrReadAddress,
    output csrWriteData,
    input  csrReadData,
    input  requestOutput
  );

  modport slave (
    input  csrWriteEnable,
    input  csrReadEnable,
    input  csrWriteAddress,
    input  csrReadAddress,
    input  csrWriteData,
    output csrReadData,
    output requestOutput
  );

endinterface

// File: rtl/user_interrupt_line.sv
// rtl/user_interrupt_line.sv - per-line sampling, edge detect and pending flop; USER_IRQ_SYNC_EN adds a 2-flop synchroniser
module user_interrupt_line (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic edge_mode,
  input  logic clear,
  output logic sampled,
  output logic pending
);

`ifdef USER_IRQ_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = raw;
`endif

  logic prev_q;
  logic rise;

  // Tracks the sample in both modes so a switch to edge mode sees a valid history.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sampled;
  end

  assign rise = sampled & ~prev_q;

  // A new rising edge beats a coincident write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst)            pending <= 1'b0;
    else if (edge_mode) begin
      if (rise)         pending <= 1'b1;
      else if (clear)   pending <= 1'b0;
    end else            pending <= sampled;
  end

endmodule

// File: rtl/user_interrupt_controller.sv
// rtl/user_interrupt_controller.sv - user-level interrupt CSRs (enable/pending/edge/raw) over 16 lines; USER_IRQ_SYNC_EN selects input synchronisation
module user_interrupt_controller
  import user_interrupt_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  user_interrupt_controller_if.slave    csr,
  input  logic [USER_IRQ_COUNT-1:0]     irqIn,
  output logic [USER_IRQ_COUNT-1:0]     userInterrupts
);

  logic [USER_IRQ_COUNT-1:0] enable_q;
  logic [USER_IRQ_COUNT-1:0] edge_q;
  logic [USER_IRQ_COUNT-1:0] pending;
  logic [USER_IRQ_COUNT-1:0] sampled;
  logic [USER_IRQ_COUNT-1:0] clear;
  csr_sel_e                  wr_sel;
  csr_sel_e                  rd_sel;
  logic                      unused_wdata_hi;

  assign wr_sel = csr.csrWriteEnable ? csr_decode(csr.csrWriteAddress) : CSR_NONE;
  assign rd_sel = csr.csrReadEnable  ? csr_decode(csr.csrReadAddress)  : CSR_NONE;

  // Upper data bits have no backing storage.
  assign unused_wdata_hi = ^csr.csrWriteData[31:USER_IRQ_COUNT];

  assign clear = (wr_sel == CSR_PENDING) ? csr.csrWriteData[USER_IRQ_COUNT-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '0;
      edge_q   <= '0;
    end else begin
      if (wr_sel == CSR_ENABLE) enable_q <= csr.csrWriteData[USER_IRQ_COUNT-1:0];
      if (wr_sel == CSR_EDGE)   edge_q   <= csr.csrWriteData[USER_IRQ_COUNT-1:0];
    end
  end

  for (genvar i = 0; i < USER_IRQ_COUNT; i++) begin : g_line
    user_interrupt_line u_line (
      .clk       (clk),
      .rst       (rst),
      .raw       (irqIn[i]),
      .edge_mode (edge_q[i]),
      .clear     (clear[i]),
      .sampled   (sampled[i]),
      .pending   (pending[i])
    );
  end

  always_comb begin
    csr.csrReadData = '0;
    case (rd_sel)
      CSR_ENABLE:  csr.csrReadData = {{(32-USER_IRQ_COUNT){1'b0}}, enable_q};
      CSR_PENDING: csr.csrReadData = {{(32-USER_IRQ_COUNT){1'b0}}, pending};
      CSR_EDGE:    csr.csrReadData = {{(32-USER_IRQ_COUNT){1'b0}}, edge_q};
      CSR_RAW:     csr.csrReadData = {{(32-USER_IRQ_COUNT){1'b0}}, sampled};
      default:     csr.csrReadData = '0;
    endcase
  end

  assign csr.requestOutput = (rd_sel != CSR_NONE);
  assign userInterrupts    = pending & enable_q;

endmodule

// File: tb/tb_user_interrupt_controller.sv
// tb/tb_user_interrupt_controller.sv - directed self-checking bench for user_interrupt_controller
module tb_user_interrupt_controller;

`ifdef USER_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq;
  logic [15:0] uint_out;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rdata;
  logic        rreq;

  user_interrupt_controller_if bus ();

  user_interrupt_controller dut (
    .clk            (clk),
    .rst            (rst),
    .csr            (bus),
    .irqIn          (irq),
    .userInterrupts (uint_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    bus.csrWriteAddress = addr;
    bus.csrWriteData    = data;
    bus.csrWriteEnable  = 1'b1;
    tick();
    bus.csrWriteEnable  = 1'b0;
    bus.csrWriteData    = 32'h0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data, output logic req);
    bus.csrReadAddress = addr;
    bus.csrReadEnable  = 1'b1;
    #1;
    data = bus.csrReadData;
    req  = bus.requestOutput;
    bus.csrReadEnable  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    irq = 16'h0;
    bus.csrWriteEnable  = 1'b0;
    bus.csrReadEnable   = 1'b0;
    bus.csrWriteAddress = 12'h0;
    bus.csrReadAddress  = 12'h0;
    bus.csrWriteData    = 32'h0;
    ticks(3);
    check("reset_uint", {16'h0, uint_out}, 32'h0);
    rst = 1'b0;
    tick();

    // reset readback of every CSR and a foreign address
    for (int a = 0; a < 4; a++) begin
      csr_read(12'hBC0 + 12'(a), rdata, rreq);
      check($sformatf("reset_data_%0d", a), rdata, 32'h0);
      check($sformatf("reset_req_%0d", a), {31'h0, rreq}, 32'h1);
    end
    csr_read(12'h300, rdata, rreq);
    check("foreign_req", {31'h0, rreq}, 32'h0);
    check("foreign_data", rdata, 32'h0);
    csr_read(12'hBC0, rdata, rreq);
    bus.csrReadEnable = 1'b0;
    check("no_enable_req", {31'h0, bus.requestOutput}, 32'h0);

    // edge line 0, single-cycle pulse
    csr_write(12'hBC2, 32'h0001);
    csr_write(12'hBC0, 32'h0001);
    irq = 16'h0001;
    tick();
    irq = 16'h0000;
    ticks(LAT);
    check("edge0_set", {16'h0, uint_out}, 32'h0001);
    ticks(3);
    check("edge0_hold", {16'h0, uint_out}, 32'h0001);
    csr_write(12'hBC1, 32'h0000);
    check("w1c_zero_noop", {16'h0, uint_out}, 32'h0001);
    csr_write(12'hBC1, 32'h0001);
    check("edge0_w1c", {16'h0, uint_out}, 32'h0000);

    // level line 5
    csr_write(12'hBC2, 32'h0000);
    csr_write(12'hBC0, 32'h0020);
    irq = 16'h0020;
    tick();
    ticks(LAT);
    check("level5_set", {16'h0, uint_out}, 32'h0020);
    csr_write(12'hBC1, 32'h0020);
    csr_read(12'hBC1, rdata, rreq);
    check("level5_w1c_high", rdata, 32'h0020);
    irq = 16'h0000;
    tick();
    ticks(LAT);
    check("level5_drop", {16'h0, uint_out}, 32'h0000);

    // edge line 3: set-wins against coincident W1C
    csr_write(12'hBC2, 32'h0008);
    csr_write(12'hBC0, 32'h0008);
    irq = 16'h0008;
    tick();
    ticks(LAT);
    check("edge3_first", {16'h0, uint_out}, 32'h0008);
    irq = 16'h0000;
    ticks(LAT + 2);
    irq = 16'h0008;
    ticks(LAT);
    csr_write(12'hBC1, 32'h0008);
    csr_read(12'hBC1, rdata, rreq);
    check("edge3_set_wins", rdata, 32'h0008);
    csr_write(12'hBC1, 32'h0008);
    csr_read(12'hBC1, rdata, rreq);
    check("edge3_clear_held_high", rdata, 32'h0000);
    irq = 16'h0000;
    ticks(LAT + 2);

    // pending independent of enable, line 15
    csr_write(12'hBC0, 32'h0000);
    csr_write(12'hBC2, 32'h8000);
    irq = 16'h8000;
    tick();
    irq = 16'h0000;
    ticks(LAT + 1);
    check("edge15_masked", {16'h0, uint_out}, 32'h0000);
    csr_read(12'hBC1, rdata, rreq);
    check("edge15_pending", rdata, 32'h00008000);
    csr_write(12'hBC0, 32'h8000);
    check("edge15_enabled", {16'h0, uint_out}, 32'h8000);
    csr_read(12'hBC2, rdata, rreq);
    check("edge_readback", rdata, 32'h00008000);

    // width masking and read-only raw
    csr_write(12'hBC0, 32'hFFFFFFFF);
    csr_read(12'hBC0, rdata, rreq);
    check("enable_width", rdata, 32'h0000FFFF);
    irq = 16'hA5A4;
    ticks(LAT + 1);
    csr_write(12'hBC3, 32'hFFFFFFFF);
    csr_read(12'hBC3, rdata, rreq);
    check("raw_readonly", rdata, 32'h0000A5A4);

    // reset clears live state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    irq = 16'h0000;
    check("rst_uint", {16'h0, uint_out}, 32'h0);
    csr_read(12'hBC1, rdata, rreq);
    check("rst_pending", rdata, 32'h0);
    csr_read(12'hBC0, rdata, rreq);
    check("rst_enable", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/user_interrupt_controller.md
USER_INTERRUPT_CONTROLLER -- requirements
Module: user_interrupt_controller

Interface
REQ-001 SHALL have parameter: none; all sizing fixed at 16 interrupt lines.
REQ-002 clk  input  1  core clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 csrWriteEnable  input  1  CSR write strobe.
REQ-005 csrReadEnable  input  1  CSR read strobe.
REQ-006 csrWriteAddress  input  12  CSR write address.
REQ-007 csrReadAddress  input  12  CSR read address.
REQ-008 csrWriteData  input  32  CSR write data.
REQ-009 csrReadData  output  32  CSR read data, zero when not addressed.
REQ-010 requestOutput  output  1  high when a read hits one of this block's CSRs.
REQ-011 irqIn  input  16  raw peripheral interrupt lines, asynchronous to clk.
REQ-012 userInterrupts  output  16  masked pending lines, drives the trap unit's userInterrupts.

Function
REQ-013 SHALL implement CSRs: 0xBC0 uirqenable (RW mask), 0xBC1 uirqpending (read; write-1-to-clear), 0xBC2 uirqedge (RW; 1=rising-edge, 0=level), 0xBC3 uirqraw (read-only, synchronised inputs); bits 31:16 read 0, writes ignored.
REQ-014 requestOutput SHALL equal csrReadEnable AND csrReadAddress in 0xBC0..0xBC3; read data combinational in same cycle.
REQ-015 Writes SHALL take effect on the clock edge where csrWriteEnable is high and address matches; writes to 0xBC3 ignored.
REQ-016 Edge line: pending bit SHALL set on the edge after sampled value goes 0->1 (sampled now 1, previous sample 0), and hold until W1C.
REQ-017 Level line: pending bit SHALL be loaded each cycle with the sampled value; W1C has no lasting effect while line high.
REQ-018 Simultaneous set condition and W1C on same bit SHALL leave the bit set (set wins).
REQ-019 Pending SHALL update regardless of uirqenable; userInterrupts SHALL be combinational uirqpending AND uirqenable.
REQ-020 Changing uirqedge SHALL not alter pending; previous-sample register updates every cycle regardless of mode.
REQ-021 W1C with data 0 SHALL change nothing.

Reset
REQ-022 On rst: uirqenable=0, uirqedge=0, uirqpending=0, synchroniser and previous-sample flops=0; userInterrupts=0, requestOutput depends only on read inputs.
REQ-023 rst asserted mid-pulse SHALL discard the event; a line still high after reset in edge mode SHALL set pending (previous sample is 0).

Configuration
REQ-024 Macro USER_IRQ_SYNC_EN defined: irqIn SHALL pass a 2-flop synchroniser; input high before edge E0 appears in pending after edge E2.
REQ-025 Macro undefined: irqIn SHALL be sampled directly (single register for edge detect only); input high before E0 appears in pending after E0.

Structure
REQ-026 Shared package SHALL hold CSR address constants (UIRQ_ENABLE_ADDR, UIRQ_PENDING_ADDR, UIRQ_EDGE_ADDR, UIRQ_RAW_ADDR) and line count constant USER_IRQ_COUNT=16.
REQ-027 Per-line logic (synchroniser, previous sample, pending flop) SHALL be one sub-module user_interrupt_line, instantiated 16 times.

Verification
REQ-028 Reset, then read 0xBC0..0xBC3 -> all 0x00000000, requestOutput=1 each read; read 0x300 -> requestOutput=0, data 0.
REQ-029 uirqedge=0x0001, uirqenable=0x0001, 1-cycle pulse on irqIn[0] -> userInterrupts=0x0001 after latency of REQ-024/025, held after pulse; W1C 0x0001 -> 0x0000 next cycle.
REQ-030 Level mode line 5, uirqenable=0x0020, irqIn[5] held high -> pending 0x0020; W1C 0x0020 -> still 0x0020; drop input -> 0x0000 after latency.
REQ-031 Edge line 3 with new rising edge sampled in same cycle as W1C 0x0008 -> pending bit 3 remains 1.
REQ-032 uirqenable=0, edge on line 15 -> userInterrupts=0, pending reads 0x00008000; set uirqenable=0x8000 -> userInterrupts=0x8000 next cycle.
REQ-033 Write 0xFFFFFFFF to 0xBC0 and 0xBC3 -> 0xBC0 reads 0x0000FFFF, 0xBC3 unchanged (reflects irqIn).
